// File: rtl/xbar_nxm_rr.sv
// N_IN x N_OUT valid/ready crossbar: per-output round-robin arbiter feeding a registered output stage.
// Define XBAR_PKT_LOCK_EN to hold an output on one input from a packet's first beat to its in_last beat.
module xbar_nxm_rr #(
  parameter int unsigned WIDTH = 320,
  parameter int unsigned N_IN  = 16,
  parameter int unsigned N_OUT = 16,
  parameter int unsigned DST_W = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  parameter int unsigned SRC_W = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN-1:0]        in_valid,
  input  logic [N_IN*WIDTH-1:0]  in_data,
  input  logic [N_IN*DST_W-1:0]  in_dst,
  input  logic [N_IN-1:0]        in_last,
  output logic [N_IN-1:0]        in_ready,
  output logic [N_OUT-1:0]       out_valid,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT*SRC_W-1:0] out_src,
  output logic [N_OUT-1:0]       out_last,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_IN-1:0]        drop
);

  logic [DST_W-1:0] dst       [N_IN];
  logic [WIDTH-1:0] in_data_a [N_IN];
  logic [N_IN-1:0]  bad_dst;
  logic [N_IN-1:0]  req       [N_OUT];
  logic [N_OUT-1:0] gnt_any;
  logic [N_OUT-1:0] can_load;
  logic [N_OUT-1:0] load;
  logic [SRC_W-1:0] gnt_idx   [N_OUT];

  logic [SRC_W-1:0] ptr_q       [N_OUT];
  logic [SRC_W-1:0] ptr_d       [N_OUT];
  logic [N_OUT-1:0] out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q  [N_OUT];
  logic [WIDTH-1:0] out_data_d  [N_OUT];
  logic [SRC_W-1:0] out_src_q   [N_OUT];
  logic [SRC_W-1:0] out_src_d   [N_OUT];
  logic [N_OUT-1:0] out_last_q, out_last_d;
`ifdef XBAR_PKT_LOCK_EN
  logic [N_OUT-1:0] lock_q, lock_d;
  logic [SRC_W-1:0] lock_src_q [N_OUT];
  logic [SRC_W-1:0] lock_src_d [N_OUT];
`endif

  function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] i);
    return (i == SRC_W'(N_IN - 1)) ? '0 : i + SRC_W'(1);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < N_IN; i++) begin
      dst[i]       = in_dst[i*DST_W +: DST_W];
      in_data_a[i] = in_data[i*WIDTH +: WIDTH];
      bad_dst[i]   = int'(dst[i]) >= int'(N_OUT);
    end
  end

  // Requests are gated by rst so nothing is granted while the block is held in reset.
  always_comb begin
    for (int unsigned j = 0; j < N_OUT; j++) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        req[j][i] = rst & in_valid[i] & ~bad_dst[i] & (dst[i] == DST_W'(j));
`ifdef XBAR_PKT_LOCK_EN
        if (lock_q[j] && (lock_src_q[j] != SRC_W'(i))) begin
          req[j][i] = 1'b0;
        end
`endif
      end
    end
  end

  // Rotating-priority search: first requester at or above ptr_q[j], wrapping past N_IN-1.
  always_comb begin
    int unsigned      idx;
    logic [SRC_W-1:0] idx_s;
    idx   = 0;
    idx_s = '0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      gnt_any[j] = 1'b0;
      gnt_idx[j] = '0;
      for (int unsigned k = 0; k < N_IN; k++) begin
        idx = 32'(ptr_q[j]) + k;
        if (idx >= N_IN) begin
          idx = idx - N_IN;
        end
        idx_s = SRC_W'(idx);
        if (!gnt_any[j] && req[j][idx_s]) begin
          gnt_any[j] = 1'b1;
          gnt_idx[j] = idx_s;
        end
      end
      can_load[j] = ~out_valid_q[j] | out_ready[j];
      load[j]     = gnt_any[j] & can_load[j];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_IN; i++) begin
      drop[i]     = rst & in_valid[i] & bad_dst[i];
      in_ready[i] = rst & in_valid[i] & bad_dst[i];
    end
    for (int unsigned j = 0; j < N_OUT; j++) begin
      if (load[j]) begin
        in_ready[gnt_idx[j]] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < N_OUT; j++) begin
      ptr_d[j]       = ptr_q[j];
      out_valid_d[j] = out_valid_q[j];
      out_data_d[j]  = out_data_q[j];
      out_src_d[j]   = out_src_q[j];
      out_last_d[j]  = out_last_q[j];
`ifdef XBAR_PKT_LOCK_EN
      lock_d[j]      = lock_q[j];
      lock_src_d[j]  = lock_src_q[j];
`endif
      if (load[j]) begin
        out_valid_d[j] = 1'b1;
        out_data_d[j]  = in_data_a[gnt_idx[j]];
        out_src_d[j]   = gnt_idx[j];
        out_last_d[j]  = in_last[gnt_idx[j]];
`ifdef XBAR_PKT_LOCK_EN
        // Pointer only moves when the packet closes; mid-packet the output stays pinned.
        if (in_last[gnt_idx[j]]) begin
          lock_d[j] = 1'b0;
          ptr_d[j]  = next_ptr(gnt_idx[j]);
        end else begin
          lock_d[j]     = 1'b1;
          lock_src_d[j] = gnt_idx[j];
        end
`else
        ptr_d[j] = next_ptr(gnt_idx[j]);
`endif
      end else if (out_ready[j]) begin
        out_valid_d[j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= '0;
      out_last_q  <= '0;
`ifdef XBAR_PKT_LOCK_EN
      lock_q      <= '0;
`endif
      for (int unsigned j = 0; j < N_OUT; j++) begin
        ptr_q[j]      <= '0;
        out_data_q[j] <= '0;
        out_src_q[j]  <= '0;
`ifdef XBAR_PKT_LOCK_EN
        lock_src_q[j] <= '0;
`endif
      end
    end else begin
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef XBAR_PKT_LOCK_EN
      lock_q      <= lock_d;
`endif
      for (int unsigned j = 0; j < N_OUT; j++) begin
        ptr_q[j]      <= ptr_d[j];
        out_data_q[j] <= out_data_d[j];
        out_src_q[j]  <= out_src_d[j];
`ifdef XBAR_PKT_LOCK_EN
        lock_src_q[j] <= lock_src_d[j];
`endif
      end
    end
  end

  always_comb begin
    out_valid = out_valid_q;
    out_last  = out_last_q;
    out_data  = '0;
    out_src   = '0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      out_data[j*WIDTH +: WIDTH] = out_data_q[j];
      out_src[j*SRC_W +: SRC_W]  = out_src_q[j];
    end
  end

endmodule
